// File: rtl/cr_kme_mc_ram_fifo.sv
// Multi-channel FIFO: N_CH queues in fixed partitions of one shared RAM,
// drained round-robin into a single registered valid/ack output port.
module cr_kme_mc_ram_fifo #(
    parameter int DATA_SIZE    = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int N_CH         = 2,
    parameter int AFULL_THRESH = FIFO_DEPTH - 1,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int NW = PW + 1,
    localparam int AW = CW + PW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] fifo_in,
    input  logic [CW-1:0]        fifo_in_ch,
    input  logic                 fifo_in_valid,
    output logic [N_CH-1:0]      fifo_in_stall,
    output logic [N_CH-1:0]      fifo_afull,
    input  logic [N_CH-1:0]      fifo_flush,
    output logic [N_CH*NW-1:0]   fifo_count,
    output logic                 fifo_ovf,
    output logic [DATA_SIZE-1:0] fifo_out,
    output logic [CW-1:0]        fifo_out_ch,
    output logic                 fifo_out_valid,
    input  logic                 fifo_out_ack
);

    logic [DATA_SIZE-1:0] ram [0:N_CH*FIFO_DEPTH-1];

    logic [N_CH-1:0]      wr_vec;
    logic [N_CH-1:0]      eligible;
    logic [N_CH*PW-1:0]   wptr_flat;
    logic [N_CH*PW-1:0]   rptr_flat;

    logic [PW-1:0]        wptr_sel;
    logic [PW-1:0]        rptr_sel;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;

    logic                 grant_found;
    logic [CW-1:0]        grant_ch;
    logic [CW-1:0]        cand_ch;
    int                   cand_idx;

    logic                 slot_free;
    logic                 rd_issue;

    logic [DATA_SIZE-1:0] rd_data_reg;
    logic                 out_valid_reg;
    logic [CW-1:0]        out_ch_reg;
    logic [CW-1:0]        last_grant_reg;
    logic                 ovf_reg;

    assign slot_free = !out_valid_reg || fifo_out_ack;
    assign rd_issue  = slot_free && grant_found;

    // Per-channel pointers and occupancy. Flush overrides any same-cycle
    // write or read; a flushed channel is never granted, so rd_en is 0 then.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [PW-1:0] wptr_reg;
            logic [PW-1:0] rptr_reg;
            logic [NW-1:0] count_reg;
            logic          wr_en;
            logic          rd_en;

            assign wr_en = fifo_in_valid && (fifo_in_ch == CW'(gi))
                           && !fifo_in_stall[gi] && !fifo_flush[gi];
            assign rd_en = rd_issue && (grant_ch == CW'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else if (fifo_flush[gi]) begin
                    wptr_reg  <= '0;
                    rptr_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (wr_en) begin
                        wptr_reg <= wptr_reg + 1'b1;
                    end
                    if (rd_en) begin
                        rptr_reg <= rptr_reg + 1'b1;
                    end
                    count_reg <= count_reg + NW'(wr_en) - NW'(rd_en);
                end
            end

            assign fifo_in_stall[gi]        = (count_reg == NW'(FIFO_DEPTH));
            assign fifo_afull[gi]           = (32'(count_reg) >= 32'(AFULL_THRESH));
            assign eligible[gi]             = (count_reg != '0) && !fifo_flush[gi];
            assign fifo_count[gi*NW +: NW]  = count_reg;
            assign wptr_flat[gi*PW +: PW]   = wptr_reg;
            assign rptr_flat[gi*PW +: PW]   = rptr_reg;
            assign wr_vec[gi]               = wr_en;
        end
    endgenerate

    // Round-robin: first eligible channel after the last granted one.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand_idx    = 0;
        cand_ch     = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand_idx = (int'(last_grant_reg) + k) % N_CH;
            cand_ch  = CW'(cand_idx);
            if (!grant_found && eligible[cand_ch]) begin
                grant_found = 1'b1;
                grant_ch    = cand_ch;
            end
        end
    end

    always_comb begin
        wptr_sel = '0;
        rptr_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (fifo_in_ch == CW'(c)) begin
                wptr_sel = wptr_flat[c*PW +: PW];
            end
            if (grant_ch == CW'(c)) begin
                rptr_sel = rptr_flat[c*PW +: PW];
            end
        end
    end

    assign wr_addr = {fifo_in_ch, wptr_sel};
    assign rd_addr = {grant_ch, rptr_sel};

    always_ff @(posedge clk) begin
        if (|wr_vec) begin
            ram[wr_addr] <= fifo_in;
        end
    end

    // The RAM's registered read port doubles as the output data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_issue) begin
            rd_data_reg <= ram[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_ch_reg     <= '0;
            last_grant_reg <= CW'(N_CH - 1);
            ovf_reg        <= 1'b0;
        end else begin
            ovf_reg <= fifo_in_valid && !(|wr_vec);
            if (slot_free) begin
                out_valid_reg <= grant_found;
            end
            if (rd_issue) begin
                out_ch_reg     <= grant_ch;
                last_grant_reg <= grant_ch;
            end
        end
    end

    assign fifo_out       = rd_data_reg;
    assign fifo_out_ch    = out_ch_reg;
    assign fifo_out_valid = out_valid_reg;
    assign fifo_ovf       = ovf_reg;

endmodule

// File: doc/cr_kme_mc_ram_fifo.md
Name: cr_kme_mc_ram_fifo

Overview:
- Multi-channel RAM-backed FIFO. N_CH independent logical queues share one RAM array, each in a fixed partition of FIFO_DEPTH entries.
- Round-robin arbitration drains the non-empty queues into a single valid/ack output port. The output is tagged with its channel.
- Adds over the single-queue RAM FIFO: per-channel full/almost-full, per-channel flush, drop/overflow reporting and occupancy counts.
- Sits between KME request sources and a shared downstream consumer.

Parameters:
- DATA_SIZE, 10, payload width in bits.
- FIFO_DEPTH, 4, entries per channel; power of 2, minimum 2.
- N_CH, 2, number of channels; minimum 2.
- AFULL_THRESH, FIFO_DEPTH-1, afull asserts when count >= this value.
- Derived: CW = max(1, clog2(N_CH)); PW = clog2(FIFO_DEPTH); NW = PW+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_in  in  DATA_SIZE  write data.
- fifo_in_ch  in  CW  target channel of the write.
- fifo_in_valid  in  1  write request.
- fifo_in_stall  out  N_CH  bit c = channel c full.
- fifo_afull  out  N_CH  bit c = count[c] >= AFULL_THRESH.
- fifo_flush  in  N_CH  bit c empties channel c.
- fifo_count  out  N_CH*NW  flattened per-channel occupancy; channel c in bits [c*NW +: NW].
- fifo_ovf  out  1  one-cycle pulse: a write was dropped.
- fifo_out  out  DATA_SIZE  read data.
- fifo_out_ch  out  CW  channel of fifo_out.
- fifo_out_valid  out  1  fifo_out holds an entry.
- fifo_out_ack  in  1  consumer accepts the entry; ignored when fifo_out_valid=0.

Behaviour:
- Reset (async): all wptr/rptr/count = 0; fifo_out_valid = 0; fifo_out = 0; fifo_out_ch = 0; fifo_ovf = 0; RR last-grant = N_CH-1, so channel 0 has first priority. RAM contents are not reset.
- fifo_in_stall[c] = (count[c] == FIFO_DEPTH); fifo_afull is also combinational from count registers only. No input-to-stall path.
- Write accept: fifo_in_valid & fifo_in_ch < N_CH & !stall[fifo_in_ch] & !fifo_flush[fifo_in_ch]. Accepted data goes to RAM[ch*FIFO_DEPTH + wptr[ch]]; wptr wraps modulo FIFO_DEPTH; count increments.
- Dropped writes: to a full channel, to an out-of-range channel, or to a channel being flushed. fifo_ovf is registered and pulses in the next cycle.
- Full is evaluated on start-of-cycle count. No fall-through: a write to a full channel is dropped even if that channel is read in the same cycle.
- Read issue in cycle N requires both:
  - slot free: !fifo_out_valid | fifo_out_ack;
  - at least one eligible channel (count > 0 and not flushed this cycle).
- Arbiter grants the first eligible channel searching from last-grant+1 modulo N_CH. The RAM read is issued and rptr[g] increments; count[g] decrements.
- RAM read latency is 1. In cycle N+1: fifo_out = RAM data, fifo_out_ch = g, fifo_out_valid = 1, last-grant = g.
- If the slot is free and no channel is eligible, fifo_out_valid goes to 0 next cycle. fifo_out and fifo_out_ch hold their last value.
- Throughput: one entry per cycle under continuous ack.
- Latency: write at cycle N into an empty channel -> read issued at N+1 -> fifo_out_valid at N+2.
- count excludes the entry held in the output register.
- Simultaneous write and read on the same channel: count unchanged, both pointers advance.
- Flush[c]: wptr, rptr and count of c = 0 next cycle. Any output-register entry already issued from c is kept and delivered. Flush has priority over a same-cycle write or read of c.
- fifo_out, fifo_out_ch and fifo_out_valid stay stable while valid & !ack.
- Reset mid-operation: all state is lost; outputs go to reset values immediately.

Test Plan:
- Reset, then write 0x155 to ch0 at cycle 0 -> fifo_out_valid=1, fifo_out=0x155, fifo_out_ch=0 at cycle 2; count0 = 1 in cycle 1, 0 in cycle 2.
- DEPTH=4: write 5 words to ch1 with no ack -> 1st word issued to output; entries 2-5 fill RAM, count1=4, stall[1]=1. A 6th write is dropped with fifo_ovf pulsing once. Then ack continuously -> data out in write order with no gaps.
- Ch0 loaded with A0,A1 and ch1 with B0,B1, ack held high -> output order A0,B0,A1,B1, one per cycle.
- ch0 count=3, afull[0]=1 (thresh 3); assert flush[0] while writing to ch0 -> count0=0, afull[0]=0, write dropped, ovf=1. The held output entry is still delivered.
- Hold ack=0 for 10 cycles with the output valid -> fifo_out and fifo_out_ch stable; no read issued; counts unchanged.
- Write with fifo_in_ch=3 when N_CH=3 -> dropped, ovf pulse, no count changes. Assert rst mid-stream -> all outputs 0 and counts 0 in the same cycle.
